keypad_scan_ctrl: RTL



---
 rtl/keypad_pkg.sv | 21 ++
 rtl/keypad_evt_fifo.sv | 64 ++++++
 rtl/keypad_scan_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared types and sizes for the 4x4 keypad scanner: matrix geometry,
// scan sequencer states and the key event record carried by the event FIFO.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

    typedef enum logic [1:0] {
        DRIVE,
        SAMPLE,
        UPDATE,
        EMIT
    } scan_state_e;

    typedef struct packed {
        logic [3:0] code;
        logic       press;
    } keypad_evt_t;

endpackage

// File: rtl/keypad_evt_fifo.sv
// Small synchronous event FIFO. A push that finds the FIFO full (with no pop in
// the same cycle) is discarded and reported by a one-cycle drop pulse.
module keypad_evt_fifo
    import keypad_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  logic [3:0] push_code_i,
    input  logic       push_press_i,
    input  logic       pop_i,
    output logic       empty_o,
    output logic [3:0] head_code_o,
    output logic       head_press_o,
    output logic       drop_o
);

    localparam int AW = $clog2(DEPTH);

    keypad_evt_t mem_q [DEPTH];
    logic [AW:0] wr_q, wr_d, rd_q, rd_d;
    logic        drop_q, drop_d;
    logic        full, empty, do_pop, do_push;
    keypad_evt_t head;

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    always_comb begin
        empty   = (wr_q == rd_q);
        full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        do_pop  = pop_i && !empty;
        do_push = push_i && (!full || do_pop);
        wr_d    = do_push ? wr_q + (AW+1)'(1) : wr_q;
        rd_d    = do_pop  ? rd_q + (AW+1)'(1) : rd_q;
        drop_d  = push_i && !do_push;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q   <= '0;
            rd_q   <= '0;
            drop_q <= 1'b0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            drop_q <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q[AW-1:0]] <= '{code: push_code_i, press: push_press_i};
        end
    end

    // Storage is not reset, so the head is forced to zero whenever nothing is queued.
    assign head         = empty ? '0 : mem_q[rd_q[AW-1:0]];
    assign empty_o      = empty;
    assign head_code_o  = head.code;
    assign head_press_o = head.press;
    assign drop_o       = drop_q;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scan sequencer: strobes rows, samples synchronized columns,
// debounces every key once per frame and queues press/release events.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int SETTLE     = 4,
    parameter int DEB_FRAMES = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  col_in,
    output logic [3:0]  row_out,
    output logic        evt_valid,
    input  logic        evt_ready,
    output logic [3:0]  evt_code,
    output logic        evt_press,
    output logic [15:0] keys_state,
    output logic        overflow
);

    localparam int CW = 3;

    scan_state_e         state_q, state_d;
    logic [1:0]          row_q, row_d;
    logic [7:0]          tick_q, tick_d;
    logic [3:0]          key_q, key_d;
    logic [3:0]          row_out_q, row_out_d;
    logic [NUM_COLS-1:0] sync1_q, sync2_q;
    logic [15:0]         snap_q, snap_d;
    logic [15:0]         keys_q, keys_d;
    logic [15:0]         chg_q, chg_d;
    logic [CW-1:0]       cnt_q [NUM_KEYS];
    logic [CW-1:0]       cnt_d [NUM_KEYS];
    logic                push, fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DRIVE;
            row_q   <= '0;
            tick_q  <= '0;
            key_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            tick_q  <= tick_d;
            key_q   <= key_d;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        tick_d  = tick_q;
        key_d   = key_q;
        unique case (state_q)
            DRIVE: begin
                if (tick_q == 8'(SETTLE - 1)) begin
                    tick_d  = '0;
                    state_d = SAMPLE;
                end else begin
                    tick_d = tick_q + 8'd1;
                end
            end
            SAMPLE: begin
                if (row_q == 2'(NUM_ROWS - 1)) begin
                    state_d = UPDATE;
                end else begin
                    row_d   = row_q + 2'd1;
                    state_d = DRIVE;
                end
            end
            UPDATE: begin
                key_d   = '0;
                state_d = EMIT;
            end
            EMIT: begin
                key_d = key_q + 4'd1;
                if (key_q == 4'(NUM_KEYS - 1)) begin
                    row_d   = '0;
                    state_d = DRIVE;
                end
            end
            default: state_d = DRIVE;
        endcase
    end

    // Each key toggles only after DEB_FRAMES consecutive frames disagreeing with its state.
    always_comb begin
        snap_d    = snap_q;
        keys_d    = keys_q;
        chg_d     = chg_q;
        cnt_d     = cnt_q;
        row_out_d = 4'b0000;
        if (state_q == DRIVE || state_q == SAMPLE) begin
            row_out_d = 4'b0001 << row_q;
        end
        if (state_q == SAMPLE) begin
            snap_d[{row_q, 2'b00} +: NUM_COLS] = sync2_q;
        end
        if (state_q == UPDATE) begin
            chg_d = '0;
            for (int k = 0; k < NUM_KEYS; k++) begin
                if (snap_q[k] == keys_q[k]) begin
                    cnt_d[k] = '0;
                end else if (cnt_q[k] == CW'(DEB_FRAMES - 1)) begin
                    keys_d[k] = ~keys_q[k];
                    cnt_d[k]  = '0;
                    chg_d[k]  = 1'b1;
                end else begin
                    cnt_d[k] = cnt_q[k] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            snap_q    <= '0;
            keys_q    <= '0;
            chg_q     <= '0;
            row_out_q <= '0;
            for (int k = 0; k < NUM_KEYS; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            sync1_q   <= col_in;
            sync2_q   <= sync1_q;
            snap_q    <= snap_d;
            keys_q    <= keys_d;
            chg_q     <= chg_d;
            row_out_q <= row_out_d;
            cnt_q     <= cnt_d;
        end
    end

    assign push = (state_q == EMIT) && chg_q[key_q];

    keypad_evt_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_code_i (key_q),
        .push_press_i(keys_q[key_q]),
        .pop_i       (evt_valid && evt_ready),
        .empty_o     (fifo_empty),
        .head_code_o (evt_code),
        .head_press_o(evt_press),
        .drop_o      (overflow)
    );

    assign evt_valid  = !fifo_empty;
    assign row_out    = row_out_q;
    assign keys_state = keys_q;

endmodule
